// File: rtl/tdm_demux_14_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexer.
package tdm_pkg;

    localparam int CHANNELS = 4;
    localparam int SLOT_W   = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t FIRST_SLOT = 2'd0;
    localparam slot_t LAST_SLOT  = 2'd3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux_14_if.sv
// Serial link input, parallel channel outputs and status of the TDM demultiplexer.
interface tdm_demux_14_if #(
    parameter int WIDTH = 1
);
    logic             demux_en_n;
    logic             demux_sync;
    logic [WIDTH-1:0] demux_in;
    logic [WIDTH-1:0] demux_out0;
    logic [WIDTH-1:0] demux_out1;
    logic [WIDTH-1:0] demux_out2;
    logic [WIDTH-1:0] demux_out3;
    logic             demux_s1;
    logic             demux_s0;
    logic             demux_valid;
    logic             demux_locked;
    logic             demux_err;

    modport master (
        output demux_en_n, demux_sync, demux_in,
        input  demux_out0, demux_out1, demux_out2, demux_out3,
        input  demux_s1, demux_s0, demux_valid, demux_locked, demux_err
    );

    modport slave (
        input  demux_en_n, demux_sync, demux_in,
        output demux_out0, demux_out1, demux_out2, demux_out3,
        output demux_s1, demux_s0, demux_valid, demux_locked, demux_err
    );
endinterface

// File: rtl/tdm_demux_14_slot_counter.sv
// Modulo-4 slot index: clear has priority over load-to-1, which beats hold; otherwise it advances.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  load_one,
    input  logic  hold,
    output slot_t slot
);

    slot_t slot_r;

    // Slot register; natural 2-bit overflow gives the 3 -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= FIRST_SLOT;
        end else if (clear) begin
            slot_r <= FIRST_SLOT;
        end else if (load_one) begin
            slot_r <= 2'd1;
        end else if (hold) begin
            slot_r <= slot_r;
        end else begin
            slot_r <= slot_r + 2'd1;
        end
    end

    assign slot = slot_r;

endmodule

// File: rtl/tdm_demux_14.sv
// TDM receive demux: aligns to the slot-0 sync marker, gathers four words and
// publishes them as one frame with a single-cycle valid pulse.
module tdm_demux_14
    import tdm_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter bit REQUIRE_SYNC = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    tdm_demux_14_if.slave bus
);

    state_e     state_r;
    state_e     state_s;
    slot_t      slot_s;
    logic       clear_s;
    logic       load_one_s;
    logic       hold_s;
    logic       shadow_wr_s;
    slot_t      shadow_idx_s;
    logic       frame_done_s;
    logic       err_s;
    logic       valid_r;
    logic       err_r;
    logic       locked_r;

    logic [WIDTH-1:0] shadow_r [CHANNELS-1];
    logic [WIDTH-1:0] out_r    [CHANNELS];

    tdm_slot_counter u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .load_one (load_one_s),
        .hold     (hold_s),
        .slot     (slot_s)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s      = state_r;
        clear_s      = 1'b0;
        load_one_s   = 1'b0;
        hold_s       = 1'b0;
        shadow_wr_s  = 1'b0;
        shadow_idx_s = slot_s;
        frame_done_s = 1'b0;
        err_s        = 1'b0;
        if (bus.demux_en_n) begin
            hold_s = 1'b1;
        end else begin
            case (state_r)
                HUNT: begin
                    if (bus.demux_sync) begin
                        shadow_wr_s  = 1'b1;
                        shadow_idx_s = FIRST_SLOT;
                        load_one_s   = 1'b1;
                        state_s      = LOCKED;
                    end else begin
                        clear_s = 1'b1;
                    end
                end
                LOCKED: begin
                    // Realign wins over frame completion, so sync on slot 3 never yields valid.
                    if (bus.demux_sync && (slot_s != FIRST_SLOT)) begin
                        err_s        = 1'b1;
                        shadow_wr_s  = 1'b1;
                        shadow_idx_s = FIRST_SLOT;
                        load_one_s   = 1'b1;
                    end else if (REQUIRE_SYNC && !bus.demux_sync && (slot_s == FIRST_SLOT)) begin
                        err_s   = 1'b1;
                        clear_s = 1'b1;
                        state_s = HUNT;
                    end else begin
                        shadow_wr_s  = (slot_s != LAST_SLOT);
                        frame_done_s = (slot_s == LAST_SLOT);
                    end
                end
                default: begin
                    clear_s = 1'b1;
                    state_s = HUNT;
                end
            endcase
        end
    end

    // State, shadow capture and registered frame/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            for (int i = 0; i < CHANNELS - 1; i++) begin
                shadow_r[i] <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                out_r[i] <= '0;
            end
        end else begin
            state_r  <= state_s;
            locked_r <= (state_s == LOCKED);
            valid_r  <= frame_done_s;
            err_r    <= err_s;
            for (int i = 0; i < CHANNELS - 1; i++) begin
                if (shadow_wr_s && (shadow_idx_s == slot_t'(i))) begin
                    shadow_r[i] <= bus.demux_in;
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
            if (frame_done_s) begin
                out_r[0] <= shadow_r[0];
                out_r[1] <= shadow_r[1];
                out_r[2] <= shadow_r[2];
                out_r[3] <= bus.demux_in;
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    out_r[i] <= out_r[i];
                end
            end
        end
    end

    assign bus.demux_out0   = out_r[0];
    assign bus.demux_out1   = out_r[1];
    assign bus.demux_out2   = out_r[2];
    assign bus.demux_out3   = out_r[3];
    assign bus.demux_s1     = slot_s[1];
    assign bus.demux_s0     = slot_s[0];
    assign bus.demux_valid  = valid_r;
    assign bus.demux_locked = locked_r;
    assign bus.demux_err    = err_r;

endmodule

// File: tb/tb_tdm_demux_14.sv
// Bench for tdm_demux_14: two instances (sync optional / sync required) fed the same
// directed link traffic, checked each cycle against a frame-collecting model.
module tb_tdm_demux_14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_n;
    logic       sync;
    logic [3:0] din;

    int errors = 0;
    int checks = 0;

    tdm_demux_14_if #(.WIDTH(4)) if0 ();
    tdm_demux_14_if #(.WIDTH(4)) if1 ();

    assign if0.demux_en_n = en_n;
    assign if0.demux_sync = sync;
    assign if0.demux_in   = din;
    assign if1.demux_en_n = en_n;
    assign if1.demux_sync = sync;
    assign if1.demux_in   = din;

    tdm_demux_14 #(.WIDTH(4), .REQUIRE_SYNC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    tdm_demux_14 #(.WIDTH(4), .REQUIRE_SYNC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    // Packed view: {out0,out1,out2,out3,s1,s0,valid,locked,err}
    logic [20:0] act [2];
    assign act[0] = {if0.demux_out0, if0.demux_out1, if0.demux_out2, if0.demux_out3,
                     if0.demux_s1, if0.demux_s0, if0.demux_valid, if0.demux_locked, if0.demux_err};
    assign act[1] = {if1.demux_out0, if1.demux_out1, if1.demux_out2, if1.demux_out3,
                     if1.demux_s1, if1.demux_s0, if1.demux_valid, if1.demux_locked, if1.demux_err};

    // Model: words collected so far in the current frame, lock flag, last published frame.
    bit         ml [2];
    int         mn [2];
    logic [3:0] mw [2][4];
    logic [3:0] eo [2][4];
    bit         ev [2];
    bit         ee [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ml[i] = 1'b0; mn[i] = 0; ev[i] = 1'b0; ee[i] = 1'b0;
                for (int j = 0; j < 4; j++) eo[i][j] = 4'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ev[i] = 1'b0;
                ee[i] = 1'b0;
                if (!en_n) begin
                    if (!ml[i]) begin
                        if (sync) begin
                            ml[i] = 1'b1; mw[i][0] = din; mn[i] = 1;
                        end
                    end else if (sync && mn[i] != 0) begin
                        ee[i] = 1'b1; mw[i][0] = din; mn[i] = 1;
                    end else if (i == 1 && mn[i] == 0 && !sync) begin
                        ee[i] = 1'b1; ml[i] = 1'b0; mn[i] = 0;
                    end else begin
                        mw[i][mn[i]] = din;
                        mn[i] = mn[i] + 1;
                        if (mn[i] == 4) begin
                            for (int j = 0; j < 4; j++) eo[i][j] = mw[i][j];
                            ev[i] = 1'b1;
                            mn[i] = 0;
                        end
                    end
                end
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [20:0] exp_v;
            logic [1:0]  slot_v;
            slot_v = 2'(mn[i]);
            exp_v  = {eo[i][0], eo[i][1], eo[i][2], eo[i][3], slot_v, ev[i], ml[i], ee[i]};
            checks = checks + 1;
            if (act[i] !== exp_v) begin
                errors = errors + 1;
                $display("FAIL cycle_dut%0d t=%0t got=%h want=%h", i, $time, act[i], exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input logic e_n, input logic s, input logic [3:0] d);
        en_n = e_n;
        sync = s;
        din  = d;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en_n  = 1'b1;
        sync  = 1'b0;
        din   = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_outs", 32'(act[0][20:5]), 32'h0000);
        chk("reset_locked", 32'(if0.demux_locked), 32'h0);

        // First frame 1,0,1,1 with sync on the first word
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h1);
        step(1'b0, 1'b0, 4'h1);
        chk("frame1_outs", 32'(act[0][20:5]), 32'h1011);
        chk("frame1_valid", 32'(if0.demux_valid), 32'h1);
        chk("frame1_locked", 32'(if0.demux_locked), 32'h1);

        // Two back-to-back synced frames
        step(1'b0, 1'b1, 4'hA); step(1'b0, 1'b0, 4'hB); step(1'b0, 1'b0, 4'hC); step(1'b0, 1'b0, 4'hD);
        chk("frame2_outs", 32'(act[0][20:5]), 32'hABCD);
        step(1'b0, 1'b1, 4'hE); step(1'b0, 1'b0, 4'hF); step(1'b0, 1'b0, 4'h0); step(1'b0, 1'b0, 4'h1);
        chk("frame3_outs", 32'(act[1][20:5]), 32'hEF01);

        // Errant sync on slot 2 realigns
        step(1'b0, 1'b1, 4'h3); step(1'b0, 1'b0, 4'h4); step(1'b0, 1'b1, 4'h5);
        chk("realign_err", 32'(if0.demux_err), 32'h1);
        chk("realign_hold", 32'(act[0][20:5]), 32'hEF01);
        step(1'b0, 1'b0, 4'h6); step(1'b0, 1'b0, 4'h7);
        chk("realign_novalid", 32'(if0.demux_valid), 32'h0);
        step(1'b0, 1'b0, 4'h8);
        chk("realign_outs", 32'(act[0][20:5]), 32'h5678);
        chk("realign_valid", 32'(if0.demux_valid), 32'h1);

        // Pause mid-frame after slot 1, sync ignored while disabled
        step(1'b0, 1'b1, 4'h9); step(1'b0, 1'b0, 4'hA);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 4'h7);
        chk("pause_slot", 32'({if0.demux_s1, if0.demux_s0}), 32'h2);
        chk("pause_valid", 32'(if0.demux_valid), 32'h0);
        step(1'b0, 1'b0, 4'hB); step(1'b0, 1'b0, 4'hC);
        chk("resume_outs", 32'(act[0][20:5]), 32'h9ABC);

        // Missing sync on frame start: only the sync-required instance drops lock
        step(1'b0, 1'b0, 4'h3);
        chk("nosync_err", 32'(if1.demux_err), 32'h1);
        chk("nosync_locked", 32'(if1.demux_locked), 32'h0);
        chk("nosync_legal", 32'(if0.demux_err), 32'h0);
        step(1'b0, 1'b0, 4'h4); step(1'b0, 1'b0, 4'h5); step(1'b0, 1'b0, 4'h6);
        chk("nosync_legal_outs", 32'(act[0][20:5]), 32'h3456);
        chk("nosync_hunt_valid", 32'(if1.demux_valid), 32'h0);
        step(1'b0, 1'b1, 4'h1); step(1'b0, 1'b0, 4'h2); step(1'b0, 1'b0, 4'h3); step(1'b0, 1'b0, 4'h4);
        chk("relock_outs", 32'(act[1][20:5]), 32'h1234);
        chk("relock_valid", 32'(if1.demux_valid), 32'h1);

        // Asynchronous reset at slot 2
        step(1'b0, 1'b1, 4'h7); step(1'b0, 1'b0, 4'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", 32'(act[0][20:5]), 32'h0000);
        chk("arst_status", 32'(act[0][4:0]), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'h5); step(1'b0, 1'b0, 4'h6);
        chk("arst_unsynced", 32'(if0.demux_locked), 32'h0);
        step(1'b0, 1'b1, 4'hD); step(1'b0, 1'b0, 4'hE); step(1'b0, 1'b0, 4'hF); step(1'b0, 1'b1, 4'h0);
        chk("slot3_sync_err", 32'(if0.demux_err), 32'h1);
        chk("slot3_sync_novalid", 32'(if0.demux_valid), 32'h0);
        step(1'b0, 1'b0, 4'h1); step(1'b0, 1'b0, 4'h2); step(1'b0, 1'b0, 4'h3);
        chk("final_outs", 32'(act[0][20:5]), 32'h0123);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
